piso_serializer: RTL and testbench

Parallel-in, serial-out transmitter that feeds the team's 4-bit right-shift SIPO receiver. It accepts WIDTH-bit words over a valid/ready handshake and emits them LSB first on a single serial line, one bit per clock. After WIDTH valid bits, the downstream right-shift register holds the original word. A one-word holding register allows back-to-back words to stream with no idle gap.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_hold_reg.sv | 30 +++
 rtl/piso_serializer.sv | 91 +++++++++
 tb/tb_piso_serializer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the PISO serializer slice.
//   state_t   : FSM encoding (IDLE / SHIFT)
//   DEF_WIDTH : default serial word width
//   cnt_w()   : width of the bit counter for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake + serial bundle for piso_serializer.
//   in_data/in_valid/in_ready : parallel word input, valid/ready
//   sdo/sdo_valid             : serial bit, LSB first, with qualifier
//   word_done                 : pulse with the last bit of each word
//   busy                      : shifting or a word is held
// master = word source / serial sink, slave = serializer.
interface piso_serializer_if #(parameter int WIDTH = piso_pkg::DEF_WIDTH);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sdo;
  logic             sdo_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, sdo, sdo_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, sdo, sdo_valid, word_done, busy
  );
endinterface

// File: rtl/piso_hold_reg.sv
// One-entry holding buffer for the serializer.
//   clk, clrb : clock, synchronous active-low clear
//   load      : capture d and mark full (wins over clr)
//   clr       : mark empty (contents handed to the shift register)
//   d/q       : word in / held word
//   full      : entry occupied
module piso_hold_reg #(parameter int WIDTH = piso_pkg::DEF_WIDTH) (
  input  logic             clk,
  input  logic             clrb,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (!clrb) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      // a load on the same cycle the old entry drains keeps it full
      q    <= d;
      full <= 1'b1;
    end else if (clr) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter, LSB first, one bit per clock.
//   clk, clrb : clock, synchronous active-low reset
//   bus       : slave side of piso_serializer_if (word in, serial out)
// A one-word holding register lets the next word follow with no idle
// gap. All outputs decode from registered state; in_ready depends only
// on hold_full.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               clrb,
  piso_serializer_if.slave   bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bitcnt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             shifting;
  logic             accept;
  logic             last_bit;
  logic             hold_load;
  logic             hold_clr;

  assign shifting = (state == SHIFT);
  assign accept   = bus.in_valid && !hold_full;
  assign last_bit = shifting && (bitcnt == LAST);

  // Mid-word accepts park in the holding register. On the last bit an
  // empty holder is bypassed and the word goes straight to shreg.
  assign hold_load = accept && shifting && (!last_bit || hold_full);
  assign hold_clr  = last_bit && hold_full;

  piso_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .clrb (clrb),
    .load (hold_load),
    .clr  (hold_clr),
    .d    (bus.in_data),
    .q    (hold),
    .full (hold_full)
  );

  always_ff @(posedge clk) begin
    if (!clrb) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= bus.in_data;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (bitcnt == LAST) begin
            bitcnt <= '0;
            if (hold_full) begin
              shreg <= hold;
            end else if (accept) begin
              shreg <= bus.in_data;
            end else begin
              shreg <= '0;
              state <= IDLE;
            end
          end else begin
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = !hold_full;
  assign bus.sdo       = shifting & shreg[0];
  assign bus.sdo_valid = shifting;
  assign bus.word_done = last_bit;
  assign bus.busy      = shifting || hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clrb;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clk  (clk),
    .clrb (clrb),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // downstream 4-bit right-shift SIPO, qualified by sdo_valid
  logic [W-1:0] sipo_q;
  always @(posedge clk) begin
    if (!clrb) sipo_q <= '0;
    else if (bus.sdo_valid) sipo_q <= {bus.sdo, sipo_q[W-1:1]};
  end

  // scoreboard: expected serial bits pushed at accept, popped per valid bit
  typedef struct {
    logic b;
    logic last;
  } sb_t;
  sb_t          bq[$];
  logic [W-1:0] wq[$];
  bit           mon_en = 0;
  bit           pend_q = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_q) begin
        pend_q = 0;
        if (wq.size() > 0) chk("sipo_word", 32'(sipo_q), 32'(wq.pop_front()));
      end
      if (bus.sdo_valid === 1'b1) begin
        if (bq.size() == 0) begin
          timeout("sb_underflow");
        end else begin
          sb_t e;
          e = bq.pop_front();
          chk("sb_sdo", 32'(bus.sdo), 32'(e.b));
          chk("sb_word_done", 32'(bus.word_done), 32'(e.last));
          if (e.last) pend_q = 1;
        end
      end else begin
        chk("idle_outs", {30'd0, bus.sdo, bus.word_done}, 32'd0);
      end
      // effects of the upcoming edge
      if (!clrb) begin
        bq.delete();
        wq.delete();
        pend_q = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < W; i++) bq.push_back('{b: bus.in_data[i], last: (i == W-1)});
      end
    end
  end

  task automatic wait_idle(input string name);
    for (int t = 0; ; t++) begin
      smp();
      if (!bus.busy) return;
      if (t > 60) begin timeout(name); return; end
      next();
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           gap;
    logic [W-1:0] exp_q;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{data: 4'h5, gap: 0, exp_q: 4'h5};
    vecs[1] = '{data: 4'hB, gap: 3, exp_q: 4'hB};
    vecs[2] = '{data: 4'h3, gap: 3, exp_q: 4'h3};
    vecs[3] = '{data: 4'hC, gap: 0, exp_q: 4'hC};
    vecs[4] = '{data: 4'h0, gap: 0, exp_q: 4'h0};
    vecs[5] = '{data: 4'hF, gap: 1, exp_q: 4'hF};
    vecs[6] = '{data: 4'h6, gap: 2, exp_q: 4'h6};

    clrb = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_outs", {28'd0, bus.sdo, bus.sdo_valid, bus.word_done, bus.busy}, 32'd0);
    next();
    clrb = 1'b1;
    mon_en = 1;
    next();

    // single word 1011: bits 1,1,0,1 at cycles 1-4, Q at 5
    begin
      logic [3:0] w;
      w = 4'b1011;
      bus.in_data = w; bus.in_valid = 1'b1;
      smp(); chk("sw_ready_c0", 32'(bus.in_ready), 32'd1);
      next(); bus.in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
        smp();
        chk("sw_valid", 32'(bus.sdo_valid), 32'd1);
        chk("sw_sdo", 32'(bus.sdo), 32'(w[c-1]));
        chk("sw_done", 32'(bus.word_done), 32'(c == 4));
        next();
      end
      smp();
      chk("sw_q", 32'(sipo_q), 32'hB);
      chk("sw_idle", {30'd0, bus.sdo_valid, bus.busy}, 32'd0);
      next(); next();
    end

    // back-to-back A then 5
    begin
      bit exp_s[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
      bus.in_data = 4'hA; bus.in_valid = 1'b1;
      smp(); next();
      bus.in_data = 4'h5;
      for (int c = 1; c <= 8; c++) begin
        smp();
        if (c == 1) chk("b2b_ready_c1", 32'(bus.in_ready), 32'd1);
        chk("b2b_valid", 32'(bus.sdo_valid), 32'd1);
        chk("b2b_sdo", 32'(bus.sdo), 32'(exp_s[c-1]));
        chk("b2b_done", 32'(bus.word_done), 32'(c == 4 || c == 8));
        next();
        bus.in_valid = 1'b0;
      end
      wait_idle("b2b_idle");
      next();
    end

    // backpressure: 1,2,3 with in_valid held
    begin
      logic [3:0] words[3] = '{4'h1, 4'h2, 4'h3};
      bit exp_rdy[6] = '{1, 1, 0, 0, 0, 1};
      bit exp_s[12]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0};
      int idx = 0;
      for (int c = 0; c <= 12; c++) begin
        bus.in_valid = (idx < 3);
        bus.in_data  = (idx < 3) ? words[idx] : 4'h0;
        smp();
        if (c <= 5) chk("bp_ready", 32'(bus.in_ready), 32'(exp_rdy[c]));
        if (c >= 1) begin
          chk("bp_valid", 32'(bus.sdo_valid), 32'd1);
          chk("bp_sdo", 32'(bus.sdo), 32'(exp_s[c-1]));
        end
        if (bus.in_valid && bus.in_ready) idx++;
        next();
      end
      bus.in_valid = 1'b0;
      chk("bp_all_taken", 32'(idx), 32'd3);
      wait_idle("bp_idle");
      next();
    end

    // last-bit bypass: 9 at cycle 0, 6 at cycle 4
    begin
      bit exp_y[4] = '{0, 1, 1, 0};
      bus.in_data = 4'h9; bus.in_valid = 1'b1;
      smp(); next(); bus.in_valid = 1'b0;
      for (int c = 1; c <= 9; c++) begin
        if (c == 4) begin bus.in_data = 4'h6; bus.in_valid = 1'b1; end
        smp();
        if (c == 4) begin
          chk("byp_ready_c4", 32'(bus.in_ready), 32'd1);
          chk("byp_done_c4", 32'(bus.word_done), 32'd1);
        end
        if (c >= 5 && c <= 8) begin
          chk("byp_ready", 32'(bus.in_ready), 32'd1);
          chk("byp_valid", 32'(bus.sdo_valid), 32'd1);
          chk("byp_sdo", 32'(bus.sdo), 32'(exp_y[c-5]));
        end
        if (c == 9) chk("byp_idle_c9", 32'(bus.sdo_valid), 32'd0);
        next();
        bus.in_valid = 1'b0;
      end
      next();
    end

    // reset mid-word: F at cycle 0, clrb low in cycle 2
    begin
      bus.in_data = 4'hF; bus.in_valid = 1'b1;
      smp(); next(); bus.in_valid = 1'b0;
      smp(); next();
      clrb = 1'b0;
      smp(); next();
      clrb = 1'b1;
      for (int c = 3; c <= 5; c++) begin
        smp();
        chk("rmw_valid", 32'(bus.sdo_valid), 32'd0);
        chk("rmw_sdo", 32'(bus.sdo), 32'd0);
        chk("rmw_done", 32'(bus.word_done), 32'd0);
        chk("rmw_ready", 32'(bus.in_ready), 32'd1);
        chk("rmw_busy", 32'(bus.busy), 32'd0);
        next();
      end
    end

    // table: streamed and gapped words, Q checked per word
    foreach (vecs[k]) begin
      bus.in_data = vecs[k].data; bus.in_valid = 1'b1;
      for (int t = 0; ; t++) begin
        smp();
        if (bus.in_ready) begin wq.push_back(vecs[k].exp_q); break; end
        if (t > 60) begin timeout("tbl_accept"); break; end
        next();
      end
      next();
      bus.in_valid = 1'b0;
      if (vecs[k].gap > 0) begin
        wait_idle("tbl_idle");
        for (int g = 0; g < vecs[k].gap; g++) begin
          if (g > 0) smp();
          chk("gap_valid", 32'(bus.sdo_valid), 32'd0);
          chk("gap_busy", 32'(bus.busy), 32'd0);
          next();
        end
      end
    end

    wait_idle("drain");
    next(); next();
    chk("sb_drain", 32'(bq.size()), 32'd0);
    chk("wq_drain", 32'(wq.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
